vmm_stream_engine: RTL and testbench
====================================

// Module: vmm_stream_engine
// PURPOSE
//  Parametrised signed matrix-vector multiplier for the reservoir datapath: y = W * x, W is N x N.
//  Replaces the fixed 4x4 VIO/ILA-driven multiplier with a streaming block.
//  Weights are preloaded through a write port. x streams in with valid/ready; y streams out one row per handshake.
//  Adds fixed-point shift, saturation, length checking and output backpressure.
// PARAMETERS
//  N      4     matrix dimension (rows = cols), N >= 2
//  DW     16    signed width of weights and x elements
//  OUT_W  32    signed width of y_data
//  SHIFT  0     arithmetic right shift applied to accumulator before output (fixed-point scaling)
//  SAT    1     1: clamp to OUT_W signed range; 0: keep LSBs (wrap)
// PORTS
//  clk      in   1               single clock, rising edge
//  rst      in   1               asynchronous, active-high reset
//  w_we     in   1               weight write strobe
//  w_addr   in   clog2(N*N)      row-major address r*N+c
//  w_data   in   DW              signed weight
//  w_err    out  1               1-cycle pulse: write dropped (engine not IDLE)
//  x_valid  in   1               x element valid
//  x_ready  out  1               engine accepts x
//  x_data   in   DW              signed x[j], column order j = 0..N-1
//  x_last   in   1               marks element N-1
//  y_valid  out  1               result valid
//  y_ready  in   1               consumer accepts result
//  y_data   out  OUT_W           scaled/saturated row result
//  y_idx    out  clog2(N)        row index of y_data
//  y_last   out  1               high with row N-1
//  err_len  out  1               1-cycle pulse on vector length mismatch
//  busy     out  1               state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, col=0, all acc=0, x_ready=1, y_valid=0, y_idx=0, y_last=0, w_err=0, err_len=0, busy=0.
//    Weight array has no reset and keeps its contents across rst.
//  - Internal ACC_W = 2*DW + clog2(N). Products are full-precision signed. Accumulation never overflows internally.
//  - FSM:
//    - IDLE: x_ready=1. A handshake (x_valid&x_ready) loads acc[r] = W[r][0]*x, col <= 1, and moves to ACCUM.
//    - ACCUM: x_ready=1. Each handshake does acc[r] += W[r][col]*x for all N rows in parallel in the same edge, col++.
//      The handshake at col==N-1 moves to DRAIN.
//    - DRAIN: x_ready=0. y_valid=1 from the first cycle after the final x handshake (latency 1).
//      Row advances only on y_valid&y_ready. y_data/y_idx are held stable while y_ready=0.
//      The handshake on row N-1 (y_last=1) returns to IDLE, col=0. The next vector may be accepted the cycle after.
//  - Output scaling: v = acc >>> SHIFT, arithmetic shift, truncation toward -inf.
//    SAT=1: v > 2^(OUT_W-1)-1 -> max; v < -2^(OUT_W-1) -> min. SAT=0: low OUT_W bits.
//  - Length rules:
//    - x_last with col != N-1: err_len pulse, acc discarded, return to IDLE, no output rows.
//    - col==N-1 handshake without x_last: err_len pulse, drain normally.
//  - w_we in IDLE: write occurs at the edge. w_we in ACCUM/DRAIN: write dropped, w_err pulse.
//    A write and the first x handshake in the same IDLE cycle: the write completes, but the product uses the old W.
//  - rst mid-vector or mid-drain: abort immediately to reset values. Partial results are lost.
//  - N=1 is unsupported. Behaviour with x_data X during a handshake is undefined.
// STRUCTURE
//  - vmm_pkg: state enum {IDLE, ACCUM, DRAIN}, width functions (ACC_W, index widths), saturation function.
//  - Sub-module vmm_mac_lane: one row's signed multiply, load/accumulate select and acc register, instantiated N times via generate.
//  - Top level holds the FSM, col/row counters, weight array, output scale/saturate mux.
// TESTING
//  - Identity: W=I (N=4), x={3,-5,7,-1} back-to-back -> y={3,-5,7,-1}, y_idx 0..3, y_last on row 3, first y_valid 1 cycle after last x.
//  - Signed full range: all W=-32768, x all -32768 (DW=16) -> each y = 4*2^30 = 2^32; SAT=1 -> y=2^31-1; SAT=0 -> y=0.
//  - Shift: SHIFT=4, W[0][0]=1, x[0]=-17, rest 0 -> y[0] = -2 (floor); other rows 0.
//  - Backpressure: y_ready toggled 0,0,1 repeatedly -> each row held 2 cycles, no row lost or duplicated, x_ready=0 throughout drain.
//  - Length: x_last on element 2 -> err_len pulse, no y_valid, next full vector correct.
//    4 elements without x_last -> err_len pulse plus normal 4-row output.
//  - Control: w_we during ACCUM -> w_err pulse and W unchanged (re-run gives same y).
//    rst asserted mid-DRAIN -> y_valid=0 same cycle, busy=0, next vector correct with retained W.

Source files
------------

// File: rtl/vmm_pkg.sv
// Shared types and width helpers for the streaming matrix-vector engine.
package vmm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    // Wide enough for any accumulator this engine is built with.
    localparam int SAT_W = 128;

    function automatic int acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp v into the signed out_w range when sat is set; otherwise pass through.
    function automatic logic signed [SAT_W-1:0] sat_clip(
        input logic signed [SAT_W-1:0] v,
        input int                      out_w,
        input bit                      sat
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] res;
        hi = {1'b0, {(SAT_W-1){1'b1}}} >> (SAT_W - out_w);
        lo = ~hi;
        if (sat && (v > hi)) begin
            res = hi;
        end else if (sat && (v < lo)) begin
            res = lo;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/vmm_mac_lane.sv
// One row of the engine: signed multiply, then load or accumulate into acc.
// Latency 1 (acc updates on the enabling edge); no backpressure of its own.
module vmm_mac_lane
    import vmm_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic signed [DW-1:0]    w,
    input  logic signed [DW-1:0]    x,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0]  w_ext;
    logic signed [2*DW-1:0]  x_ext;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;

    assign w_ext    = {{DW{w[DW-1]}}, w};
    assign x_ext    = {{DW{x[DW-1]}}, x};
    assign prod     = w_ext * x_ext;
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= load ? prod_ext : acc + prod_ext;
        end
    end

endmodule

// File: rtl/vmm_stream_engine.sv
// Streaming y = W*x: x elements in column order, one y row out per handshake.
// First y_valid one cycle after the last x; x_ready low while draining, rows held under y_ready=0.
module vmm_stream_engine
    import vmm_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0,
    parameter int SAT   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_we,
    input  logic [$clog2(N*N)-1:0]    w_addr,
    input  logic signed [DW-1:0]      w_data,
    output logic                      w_err,
    input  logic                      x_valid,
    output logic                      x_ready,
    input  logic signed [DW-1:0]      x_data,
    input  logic                      x_last,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic signed [OUT_W-1:0]   y_data,
    output logic [$clog2(N)-1:0]      y_idx,
    output logic                      y_last,
    output logic                      err_len,
    output logic                      busy
);

    localparam int ACC_W = acc_w(DW, N);
    localparam int AW    = $clog2(N*N);
    localparam int IW    = $clog2(N);

    state_t                  state;
    logic [IW-1:0]           col;
    logic [IW-1:0]           row;
    logic signed [DW-1:0]    w_mem [2**AW];
    logic signed [ACC_W-1:0] acc [N];
    logic                    x_hs;
    logic                    y_hs;
    logic                    lane_load;

    assign x_hs      = x_valid & x_ready;
    assign y_hs      = y_valid & y_ready;
    assign lane_load = (state == IDLE);

    // Weights survive reset; a write racing the first x lands after the read.
    always_ff @(posedge clk) begin
        if (w_we && (state == IDLE)) begin
            w_mem[w_addr] <= w_data;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [AW-1:0] widx;
        assign widx = AW'(r * N) + AW'(col);

        vmm_mac_lane #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (x_hs),
            .load (lane_load),
            .w    (w_mem[widx]),
            .x    (x_data),
            .acc  (acc[r])
        );
    end

    logic signed [ACC_W-1:0] acc_sel;
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [SAT_W-1:0] v_clip;
    logic                    unused_hi;

    assign acc_sel   = acc[row];
    assign acc_shr   = acc_sel >>> SHIFT;
    assign v_clip    = sat_clip({{(SAT_W-ACC_W){acc_shr[ACC_W-1]}}, acc_shr}, OUT_W, SAT != 0);
    assign y_data    = v_clip[OUT_W-1:0];
    assign unused_hi = ^v_clip[SAT_W-1:OUT_W];
    assign y_idx     = row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            x_ready <= 1'b1;
            y_valid <= 1'b0;
            y_last  <= 1'b0;
            w_err   <= 1'b0;
            err_len <= 1'b0;
            busy    <= 1'b0;
        end else begin
            w_err   <= w_we && (state != IDLE);
            err_len <= 1'b0;
            case (state)
                IDLE: begin
                    if (x_hs) begin
                        if (x_last) begin
                            err_len <= 1'b1;
                        end else begin
                            col   <= IW'(1);
                            state <= ACCUM;
                            busy  <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (x_hs) begin
                        if (col == IW'(N-1)) begin
                            // Missing x_last is flagged but the rows are still produced.
                            err_len <= !x_last;
                            state   <= DRAIN;
                            x_ready <= 1'b0;
                            y_valid <= 1'b1;
                            y_last  <= 1'b0;
                            row     <= '0;
                            col     <= '0;
                        end else if (x_last) begin
                            err_len <= 1'b1;
                            state   <= IDLE;
                            col     <= '0;
                            busy    <= 1'b0;
                        end else begin
                            col <= col + IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (y_hs) begin
                        if (y_last) begin
                            state   <= IDLE;
                            y_valid <= 1'b0;
                            y_last  <= 1'b0;
                            row     <= '0;
                            x_ready <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            row    <= row + IW'(1);
                            y_last <= (row == IW'(N-2));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmm_stream_engine.sv
// Three engine builds (SHIFT0/SAT1, SHIFT0/SAT0, SHIFT4/SAT1) share one stimulus stream.
// Expected rows go to a scoreboard queue as vectors are sent and are popped on each y handshake.
module tb_vmm_stream_engine;

    localparam int N = 4;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  idx;
        logic        last;
        int          cfg;
    } exp_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        w_we    = 1'b0;
    logic [3:0]  w_addr  = '0;
    logic [15:0] w_data  = '0;
    logic        x_valid = 1'b0;
    logic        x_last  = 1'b0;
    logic [15:0] x_data  = '0;
    logic        y_ready = 1'b1;

    logic [2:0]  w_err;
    logic [2:0]  x_ready;
    logic [2:0]  y_valid;
    logic [2:0]  y_last;
    logic [2:0]  err_len;
    logic [2:0]  busy;
    logic [31:0] y_data [3];
    logic [1:0]  y_idx [3];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   w_m [16];
    exp_t sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        vmm_stream_engine #(
            .N     (4),
            .DW    (16),
            .OUT_W (32),
            .SHIFT ((g == 2) ? 4 : 0),
            .SAT   ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .w_we    (w_we),
            .w_addr  (w_addr),
            .w_data  (w_data),
            .w_err   (w_err[g]),
            .x_valid (x_valid),
            .x_ready (x_ready[g]),
            .x_data  (x_data),
            .x_last  (x_last),
            .y_valid (y_valid[g]),
            .y_ready (y_ready),
            .y_data  (y_data[g]),
            .y_idx   (y_idx[g]),
            .y_last  (y_last[g]),
            .err_len (err_len[g]),
            .busy    (busy[g])
        );
    end

    function automatic logic [31:0] model_y(input int cfg, input int row, input int xv[4]);
        longint acc;
        longint maxv;
        longint minv;
        maxv = 64'sh7FFF_FFFF;
        minv = -maxv - 1;
        acc  = 0;
        for (int j = 0; j < N; j++) begin
            acc += longint'(w_m[row*N + j]) * longint'(xv[j]);
        end
        acc = acc >>> ((cfg == 2) ? 4 : 0);
        if (cfg != 1) begin
            if (acc > maxv) acc = maxv;
            else if (acc < minv) acc = minv;
        end
        return acc[31:0];
    endfunction

    task automatic push_expect(input int xv[4]);
        exp_t e;
        for (int r = 0; r < N; r++) begin
            for (int g = 0; g < 3; g++) begin
                e.d    = model_y(g, r, xv);
                e.idx  = 2'(r);
                e.last = (r == N-1);
                e.cfg  = g;
                sb.push_back(e);
            end
        end
    endtask

    // Scoreboard consumer: every accepted row must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 3; g++) begin
                if (y_valid[g] && y_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL row_unexpected cfg%0d: got data=%0h idx=%0d, required no row", g, y_data[g], y_idx[g]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.cfg != g || y_data[g] !== e.d || y_idx[g] !== e.idx || y_last[g] !== e.last) begin
                            n_fail++;
                            $display("FAIL row cfg%0d: got data=%0h idx=%0d last=%0b, required cfg%0d data=%0h idx=%0d last=%0b",
                                     g, y_data[g], y_idx[g], y_last[g], e.cfg, e.d, e.idx, e.last);
                        end
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic put_x(input logic [15:0] d, input bit last);
        int t;
        t       = 0;
        x_valid = 1'b1;
        x_data  = d;
        x_last  = last;
        @(negedge clk);
        while (!x_ready[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL put_x_timeout: x_ready=%0b after %0d cycles, required 1", x_ready[0], t);
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        x_last  = 1'b0;
    endtask

    task automatic send_vec(input int xv[4], input bit fin_last);
        for (int j = 0; j < N; j++) begin
            put_x(16'(xv[j]), (j == N-1) ? fin_last : 1'b0);
        end
        push_expect(xv);
    endtask

    task automatic wr_w(input int addr, input int val);
        w_we   = 1'b1;
        w_addr = 4'(addr);
        w_data = 16'(val);
        @(posedge clk);
        #1;
        w_we      = 1'b0;
        w_m[addr] = val;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy != 3'b000) && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 60) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d rows outstanding, busy=%b, required 0 and 000", sb.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if ({x_ready[g], y_valid[g], y_idx[g], y_last[g], w_err[g], err_len[g], busy[g]} !== 8'b1000_0000) begin
                n_fail++;
                $display("FAIL reset cfg%0d: got rdy/vld/idx/last/werr/elen/busy=%b%b%b%b%b%b%b, required 1 0 00 0 0 0 0",
                         g, x_ready[g], y_valid[g], y_idx[g], y_last[g], w_err[g], err_len[g], busy[g]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int xv[4] = '{3, -5, 7, -1};
        for (int a = 0; a < 16; a++) wr_w(a, (a % 5 == 0) ? 1 : 0);
        y_ready = 1'b1;
        for (int j = 0; j < N; j++) put_x(16'(xv[j]), j == N-1);
        push_expect(xv);
        @(negedge clk);
        n_checks++;
        if (y_valid !== 3'b111 || x_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL first_y_latency: got y_valid=%b x_ready=%b, required 111 000", y_valid, x_ready);
        end
        wait_drain();
    endtask

    task automatic test_full_range();
        int xv[4] = '{-32768, -32768, -32768, -32768};
        for (int a = 0; a < 16; a++) wr_w(a, -32768);
        send_vec(xv, 1'b1);
        wait_drain();
    endtask

    task automatic test_shift();
        int xv[4] = '{-17, 0, 0, 0};
        for (int a = 0; a < 16; a++) wr_w(a, (a == 0) ? 1 : 0);
        send_vec(xv, 1'b1);
        wait_drain();
    endtask

    task automatic test_backpressure();
        int          xv[4];
        logic [31:0] pd;
        logic [1:0]  pi;
        bit          hold;
        hold = 1'b0;
        pd   = '0;
        pi   = '0;
        for (int a = 0; a < 16; a++) wr_w(a, int'($urandom_range(0, 200)) - 100);
        for (int j = 0; j < N; j++) xv[j] = int'($urandom_range(0, 2000)) - 1000;
        y_ready = 1'b0;
        send_vec(xv, 1'b1);
        for (int k = 0; k < 3*N + 3; k++) begin
            y_ready = (k % 3 == 2);
            @(negedge clk);
            if (y_valid[0]) begin
                n_checks++;
                if (x_ready[0] !== 1'b0 || (hold && (y_data[0] !== pd || y_idx[0] !== pi))) begin
                    n_fail++;
                    $display("FAIL bp_hold k=%0d: got x_ready=%0b data=%0h idx=%0d, required 0 data=%0h idx=%0d",
                             k, x_ready[0], y_data[0], y_idx[0], pd, pi);
                end
            end
            hold = y_valid[0] && !y_ready;
            pd   = y_data[0];
            pi   = y_idx[0];
            @(posedge clk);
            #1;
        end
        y_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_length();
        int xv[4] = '{11, -22, 33, -44};
        put_x(16'(5), 1'b0);
        put_x(16'(6), 1'b0);
        put_x(16'(7), 1'b1);
        @(negedge clk);
        n_checks++;
        if (err_len !== 3'b111 || y_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL short_err: got err_len=%b y_valid=%b, required 111 000", err_len, y_valid);
        end
        @(negedge clk);
        n_checks++;
        if (err_len !== 3'b000) begin
            n_fail++;
            $display("FAIL short_pulse: got err_len=%b, required 000", err_len);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (y_valid !== 3'b000 || busy !== 3'b000) begin
                n_fail++;
                $display("FAIL short_quiet k=%0d: got y_valid=%b busy=%b, required 000 000", k, y_valid, busy);
            end
        end
        @(posedge clk);
        #1;
        send_vec(xv, 1'b1);
        @(negedge clk);
        n_checks++;
        if (err_len !== 3'b000) begin
            n_fail++;
            $display("FAIL full_no_err: got err_len=%b, required 000", err_len);
        end
        wait_drain();
        send_vec(xv, 1'b0);
        @(negedge clk);
        n_checks++;
        if (err_len !== 3'b111 || y_valid !== 3'b111) begin
            n_fail++;
            $display("FAIL long_err: got err_len=%b y_valid=%b, required 111 111", err_len, y_valid);
        end
        wait_drain();
    endtask

    task automatic test_control();
        int xv[4] = '{100, -200, 300, -400};
        int old0;
        put_x(16'(xv[0]), 1'b0);
        put_x(16'(xv[1]), 1'b0);
        w_we   = 1'b1;
        w_addr = 4'd5;
        w_data = 16'(1234);
        @(posedge clk);
        #1;
        w_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (w_err !== 3'b111) begin
            n_fail++;
            $display("FAIL w_err_accum: got w_err=%b, required 111", w_err);
        end
        @(posedge clk);
        #1;
        put_x(16'(xv[2]), 1'b0);
        put_x(16'(xv[3]), 1'b1);
        push_expect(xv);
        wait_drain();
        send_vec(xv, 1'b1);
        wait_drain();
        // Write to W[0][0] on the same edge as the first x: the product still sees the old weight.
        old0   = w_m[0];
        w_we   = 1'b1;
        w_addr = 4'd0;
        w_data = 16'(old0 + 7);
        put_x(16'(xv[0]), 1'b0);
        w_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (w_err !== 3'b000) begin
            n_fail++;
            $display("FAIL w_err_idle: got w_err=%b, required 000", w_err);
        end
        @(posedge clk);
        #1;
        for (int j = 1; j < N; j++) put_x(16'(xv[j]), j == N-1);
        push_expect(xv);
        w_m[0] = old0 + 7;
        wait_drain();
        send_vec(xv, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_mid_drain();
        int xv[4]  = '{9, 8, -7, 6};
        int xv2[4] = '{-1, 2, -3, 4};
        y_ready = 1'b0;
        send_vec(xv, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (y_valid !== 3'b000 || busy !== 3'b000 || x_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_abort: got y_valid=%b busy=%b x_ready=%b, required 000 000 111", y_valid, busy, x_ready);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        y_ready = 1'b1;
        send_vec(xv2, 1'b1);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_full_range();
        test_shift();
        test_backpressure();
        test_length();
        test_control();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
